// File: rtl/cpu_seq_ctrl.sv
// ----------------------------------------------------------------------------
// cpu_seq_ctrl
//
// Multi-cycle sequencer for the 8-bit CPU datapath (8x8 register file, 3-bit
// ALU op, 32-bit PC).
//
// Each instruction takes the path FETCH -> DECODE -> EXEC -> WB.
// - FETCH holds imem_req high until imem_ack arrives.
// - DECODE registers the control fields.
// - EXEC presents them to the datapath.
// - WB strobes the register-file write and advances the PC.
//
// A fetch that waits too long, or an unknown opcode, parks the sequencer in a
// sticky FAULT state. Only reset leaves FAULT.
//
// Build option:
//   CPU_SEQ_BRANCH_EN - enables opcode 06 (JMP) and 07 (BEQ). Without it, both
//                       opcodes are illegal.
//
// Parameters:
//   RESET_PC   PC value loaded on reset
//   TIMEOUT    FETCH cycles without imem_ack before a timeout fault (>= 1)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   run          1 = execute; 0 = stop after the current instruction
//   imem_req     fetch request (high for the whole of FETCH)
//   imem_addr    fetch address (= pc)
//   imem_ack     fetch complete; imem_data is valid in the same cycle
//   imem_data    instruction word
//   alu_zero     ALU result is zero (sampled at the end of EXEC)
//   pc           current program counter
//   alu_op       ALU operation
//   imm_sel      1 = ALU operand 2 comes from imm_val
//   imm_val      immediate, ir[7:0]
//   rd_addr1     register read address 1, ir[10:8]
//   rd_addr2     register read address 2, ir[2:0]
//   wr_addr      register write address, ir[18:16]
//   wr_en        register-file write strobe (one WB cycle)
//   busy         sequencer is neither IDLE nor FAULT
//   fault        sticky fault flag
//   fault_code   00 none, 01 illegal opcode, 10 fetch timeout
//   retired      retired-instruction count, wraps
// ----------------------------------------------------------------------------
module cpu_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        alu_zero,
    output logic [31:0] pc,
    output logic [2:0]  alu_op,
    output logic        imm_sel,
    output logic [7:0]  imm_val,
    output logic [2:0]  rd_addr1,
    output logic [2:0]  rd_addr2,
    output logic [2:0]  wr_addr,
    output logic        wr_en,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [15:0] retired
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_FAULT
    } state_t;

    state_t             state_reg,      state_next;
    logic [31:0]        pc_reg,         pc_next;
    logic [31:0]        ir_reg,         ir_next;
    logic [CNT_W-1:0]   wait_cnt_reg,   wait_cnt_next;
    logic [2:0]         alu_op_reg,     alu_op_next;
    logic               imm_sel_reg,    imm_sel_next;
    logic [7:0]         imm_val_reg,    imm_val_next;
    logic [2:0]         rd_addr1_reg,   rd_addr1_next;
    logic [2:0]         rd_addr2_reg,   rd_addr2_next;
    logic [2:0]         wr_addr_reg,    wr_addr_next;
    logic               write_reg,      write_next;
    logic               jump_reg,       jump_next;
    logic               beq_reg,        beq_next;
    logic               zero_reg,       zero_next;
    logic [1:0]         fault_code_reg, fault_code_next;
    logic [15:0]        retired_reg,    retired_next;

    // Opcode decode of the held instruction word
    logic       dec_legal;
    logic [2:0] dec_alu_op;
    logic       dec_imm_sel;
    logic       dec_write;
    logic       dec_jump;
    logic       dec_beq;

    always_comb begin
        dec_legal   = 1'b1;
        dec_alu_op  = 3'b000;
        dec_imm_sel = 1'b0;
        dec_write   = 1'b0;
        dec_jump    = 1'b0;
        dec_beq     = 1'b0;
        case (ir_reg[31:24])
            8'h00: begin dec_alu_op = 3'b000; dec_imm_sel = 1'b1; dec_write = 1'b1; end // LOADI
            8'h01: begin dec_alu_op = 3'b001; dec_write = 1'b1; end                     // MOV
            8'h02: begin dec_alu_op = 3'b010; dec_write = 1'b1; end                     // ADD
            8'h03: begin dec_alu_op = 3'b011; dec_write = 1'b1; end                     // SUB
            8'h04: begin dec_alu_op = 3'b100; dec_write = 1'b1; end                     // AND
            8'h05: begin dec_alu_op = 3'b101; dec_write = 1'b1; end                     // OR
`ifdef CPU_SEQ_BRANCH_EN
            8'h06: begin dec_jump = 1'b1; end                                           // JMP
            8'h07: begin dec_alu_op = 3'b011; dec_beq = 1'b1; end                       // BEQ (compare by SUB)
`else
            8'h06, 8'h07: dec_legal = 1'b0;
`endif
            default: dec_legal = 1'b0;
        endcase
    end

    // Branch target: word offset ir[23:16], sign-extended, relative to pc+4.
    // Without branch support, jump_reg/beq_reg never set and the target is
    // never selected.
    logic [31:0] pc_seq;
    logic [31:0] branch_off;
    logic        take_branch;

    assign pc_seq      = pc_reg + 32'd4;
    assign branch_off  = {{22{ir_reg[23]}}, ir_reg[23:16], 2'b00};
    assign take_branch = jump_reg | (beq_reg & zero_reg);

    // Instruction bits with no field in this encoding
    logic unused_ir_bits;
    assign unused_ir_bits = &{1'b0, ir_reg[15:11]};

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        ir_next         = ir_reg;
        wait_cnt_next   = wait_cnt_reg;
        alu_op_next     = alu_op_reg;
        imm_sel_next    = imm_sel_reg;
        imm_val_next    = imm_val_reg;
        rd_addr1_next   = rd_addr1_reg;
        rd_addr2_next   = rd_addr2_reg;
        wr_addr_next    = wr_addr_reg;
        write_next      = write_reg;
        jump_next       = jump_reg;
        beq_next        = beq_reg;
        zero_next       = zero_reg;
        fault_code_next = fault_code_reg;
        retired_next    = retired_reg;

        case (state_reg)
            S_IDLE: begin
                wait_cnt_next = '0;
                if (run) begin
                    state_next = S_FETCH;
                end
            end

            S_FETCH: begin
                if (imem_ack) begin
                    ir_next       = imem_data;
                    wait_cnt_next = '0;
                    state_next    = S_DECODE;
                end else if (wait_cnt_reg == CNT_LAST) begin
                    // This is FETCH cycle number TIMEOUT without an ack.
                    state_next      = S_FAULT;
                    fault_code_next = 2'b10;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end

            S_DECODE: begin
                if (dec_legal) begin
                    alu_op_next   = dec_alu_op;
                    imm_sel_next  = dec_imm_sel;
                    imm_val_next  = ir_reg[7:0];
                    rd_addr1_next = ir_reg[10:8];
                    rd_addr2_next = ir_reg[2:0];
                    wr_addr_next  = ir_reg[18:16];
                    write_next    = dec_write;
                    jump_next     = dec_jump;
                    beq_next      = dec_beq;
                    state_next    = S_EXEC;
                end else begin
                    // The faulting instruction leaves pc and the control
                    // fields untouched.
                    state_next      = S_FAULT;
                    fault_code_next = 2'b01;
                end
            end

            S_EXEC: begin
                zero_next  = alu_zero;
                state_next = S_WB;
            end

            S_WB: begin
                pc_next      = take_branch ? (pc_seq + branch_off) : pc_seq;
                retired_next = retired_reg + 16'd1;
                state_next   = run ? S_FETCH : S_IDLE;
            end

            S_FAULT: begin
                state_next = S_FAULT;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= S_IDLE;
            pc_reg         <= RESET_PC;
            ir_reg         <= '0;
            wait_cnt_reg   <= '0;
            alu_op_reg     <= '0;
            imm_sel_reg    <= 1'b0;
            imm_val_reg    <= '0;
            rd_addr1_reg   <= '0;
            rd_addr2_reg   <= '0;
            wr_addr_reg    <= '0;
            write_reg      <= 1'b0;
            jump_reg       <= 1'b0;
            beq_reg        <= 1'b0;
            zero_reg       <= 1'b0;
            fault_code_reg <= '0;
            retired_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            ir_reg         <= ir_next;
            wait_cnt_reg   <= wait_cnt_next;
            alu_op_reg     <= alu_op_next;
            imm_sel_reg    <= imm_sel_next;
            imm_val_reg    <= imm_val_next;
            rd_addr1_reg   <= rd_addr1_next;
            rd_addr2_reg   <= rd_addr2_next;
            wr_addr_reg    <= wr_addr_next;
            write_reg      <= write_next;
            jump_reg       <= jump_next;
            beq_reg        <= beq_next;
            zero_reg       <= zero_next;
            fault_code_reg <= fault_code_next;
            retired_reg    <= retired_next;
        end
    end

    assign imem_req   = (state_reg == S_FETCH);
    assign imem_addr  = pc_reg;
    assign pc         = pc_reg;
    assign alu_op     = alu_op_reg;
    assign imm_sel    = imm_sel_reg;
    assign imm_val    = imm_val_reg;
    assign rd_addr1   = rd_addr1_reg;
    assign rd_addr2   = rd_addr2_reg;
    assign wr_addr    = wr_addr_reg;
    assign wr_en      = (state_reg == S_WB) && write_reg;
    assign busy       = (state_reg != S_IDLE) && (state_reg != S_FAULT);
    assign fault      = (state_reg == S_FAULT);
    assign fault_code = fault_code_reg;
    assign retired    = retired_reg;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
module tb_cpu_seq_ctrl;

    localparam int TIMEOUT = 16;
`ifdef CPU_SEQ_BRANCH_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        alu_zero;
    logic [31:0] pc;
    logic [2:0]  alu_op;
    logic        imm_sel;
    logic [7:0]  imm_val;
    logic [2:0]  rd_addr1;
    logic [2:0]  rd_addr2;
    logic [2:0]  wr_addr;
    logic        wr_en;
    logic        busy;
    logic        fault;
    logic [1:0]  fault_code;
    logic [15:0] retired;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [15:0] m_retired;

    cpu_seq_ctrl #(.RESET_PC(32'h0000_0000), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .alu_zero(alu_zero), .pc(pc), .alu_op(alu_op),
        .imm_sel(imm_sel), .imm_val(imm_val),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .wr_addr(wr_addr),
        .wr_en(wr_en), .busy(busy), .fault(fault),
        .fault_code(fault_code), .retired(retired)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic bit ref_legal(input logic [7:0] op);
        return (op <= 8'h05) || (BR_EN && (op == 8'h06 || op == 8'h07));
    endfunction

    function automatic bit ref_writes(input logic [7:0] op);
        return op <= 8'h05;
    endfunction

    function automatic logic [2:0] ref_alu_op(input logic [7:0] op);
        case (op)
            8'h00: return 3'b000;
            8'h01: return 3'b001;
            8'h02: return 3'b010;
            8'h03: return 3'b011;
            8'h04: return 3'b100;
            8'h05: return 3'b101;
            8'h07: return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [31:0] ref_next_pc(input logic [31:0] cur, input logic [31:0] instr,
                                                input bit zero);
        logic [7:0]  op;
        logic [31:0] off;
        op  = instr[31:24];
        off = {{24{instr[23]}}, instr[23:16]};
        if (BR_EN && (op == 8'h06 || (op == 8'h07 && zero)))
            return cur + 32'd4 + off * 32'd4;
        return cur + 32'd4;
    endfunction

    // ---------------- helpers (stimulus only) ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_data = '0; alu_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        m_pc = 32'h0; m_retired = 16'h0;
    endtask

    // From IDLE: raise run and move into the first FETCH cycle.
    task automatic start_fetch();
        run = 1'b1;
        step();
    endtask

    // Runs one legal instruction from the current FETCH cycle and checks it.
    task automatic do_instr(input logic [31:0] instr, input int delay, input bit zero, input bit stop);
        logic [7:0]  op;
        logic [2:0]  wr_seen;
        logic [2:0]  g_alu, g_rd1, g_rd2, g_wa;
        logic        g_isel;
        logic [7:0]  g_ival;
        logic        g_req_mid;
        logic [2:0]  e_wr;
        op = instr[31:24];

        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
            n_fail++;
            $display("FAIL fetch_start: imem_req=%0b imem_addr=%08h, required 1 / %08h", imem_req, imem_addr, m_pc);
        end
        for (int i = 0; i < delay; i++) begin
            imem_ack = 1'b0; imem_data = $urandom;
            step();
        end
        n_tests++;
        if (imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_wait: imem_req=%0b after %0d wait cycles, required 1", imem_req, delay);
        end
        imem_ack = 1'b1; imem_data = instr;
        step();
        // DECODE
        imem_ack = 1'b0; imem_data = $urandom;
        if (stop) run = 1'b0;
        wr_seen[0] = wr_en; g_req_mid = imem_req;
        alu_zero = 1'($urandom);
        step();
        // EXEC: a stray ack with garbage data here must be ignored
        wr_seen[1] = wr_en; g_req_mid |= imem_req;
        g_alu = alu_op; g_isel = imm_sel; g_ival = imm_val; g_rd1 = rd_addr1; g_rd2 = rd_addr2;
        alu_zero = zero; imem_ack = 1'b1; imem_data = $urandom;
        step();
        // WB
        imem_ack = 1'b0;
        wr_seen[2] = wr_en; g_wa = wr_addr; g_req_mid |= imem_req;
        alu_zero = ~zero;
        step();

        m_pc = ref_next_pc(m_pc, instr, zero);
        m_retired = m_retired + 16'd1;
        e_wr = ref_writes(op) ? 3'b100 : 3'b000;

        n_tests++;
        if (g_req_mid !== 1'b0) begin
            n_fail++; $display("FAIL req_mid: imem_req seen %0b during DECODE/EXEC/WB, required 0", g_req_mid);
        end
        if (op != 8'h06) begin
            n_tests++;
            if (g_alu !== ref_alu_op(op)) begin
                n_fail++; $display("FAIL alu_op: op=%02h got %03b, required %03b", op, g_alu, ref_alu_op(op));
            end
        end
        n_tests++;
        if (g_isel !== (op == 8'h00) || g_ival !== instr[7:0]) begin
            n_fail++; $display("FAIL imm: op=%02h got sel=%0b val=%02h, required %0b / %02h",
                               op, g_isel, g_ival, (op == 8'h00), instr[7:0]);
        end
        n_tests++;
        if (g_rd1 !== instr[10:8] || g_rd2 !== instr[2:0]) begin
            n_fail++; $display("FAIL rd_addr: got %0d/%0d, required %0d/%0d", g_rd1, g_rd2, instr[10:8], instr[2:0]);
        end
        n_tests++;
        if (wr_seen !== e_wr) begin
            n_fail++; $display("FAIL wr_en: op=%02h per-cycle %03b, required %03b", op, wr_seen, e_wr);
        end
        if (ref_writes(op)) begin
            n_tests++;
            if (g_wa !== instr[18:16]) begin
                n_fail++; $display("FAIL wr_addr: got %0d, required %0d", g_wa, instr[18:16]);
            end
        end
        n_tests++;
        if (pc !== m_pc || retired !== m_retired) begin
            n_fail++; $display("FAIL pc_retired: pc=%08h retired=%0d, required %08h / %0d", pc, retired, m_pc, m_retired);
        end
        n_tests++;
        if (imem_req !== !stop || busy !== !stop) begin
            n_fail++; $display("FAIL after_wb: imem_req=%0b busy=%0b, required %0b", imem_req, busy, !stop);
        end
        $display("[TB] instr=%08h op=%02h wait=%0d zero=%0b stop=%0b pc=%08h retired=%0d",
                 instr, op, delay, zero, stop, pc, retired);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_data = '0; alu_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({imem_req, wr_en, busy, fault, fault_code, alu_op, imm_sel, imm_val, rd_addr1, rd_addr2, wr_addr} !== '0
            || retired !== 16'h0 || pc !== 32'h0 || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_values: req=%0b wr=%0b busy=%0b fault=%0b pc=%08h retired=%0d, required all zero",
                               imem_req, wr_en, busy, fault, pc, retired);
        end
        rst = 1'b1; m_pc = 32'h0; m_retired = 16'h0;
        // Idle with run=0, stray acks must not start anything
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1; imem_data = $urandom;
            step();
        end
        imem_ack = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || imem_req !== 1'b0 || pc !== 32'h0) begin
            n_fail++; $display("FAIL idle_hold: busy=%0b req=%0b pc=%08h, required 0/0/0", busy, imem_req, pc);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_add();
        apply_reset();
        start_fetch();
        do_instr(32'h0203_0102, 0, 1'b0, 1'b0);
        n_tests++;
        if (pc !== 32'h4 || retired !== 16'd1) begin
            n_fail++; $display("FAIL add_pc: pc=%08h retired=%0d, required 00000004 / 1", pc, retired);
        end
    endtask

    task automatic test_loadi_wait();
        apply_reset();
        start_fetch();
        do_instr(32'h0005_007F, 3, 1'b0, 1'b1);
        n_tests++;
        if (pc !== 32'h4) begin
            n_fail++; $display("FAIL loadi_pc: pc=%08h, required 00000004", pc);
        end
    endtask

    task automatic test_random();
        logic [7:0]  op;
        logic [31:0] instr;
        bit          stop;
        apply_reset();
        start_fetch();
        for (int k = 0; k < 40; k++) begin
            op    = 8'($urandom_range(0, BR_EN ? 7 : 5));
            instr = {op, 24'($urandom)};
            stop  = ($urandom_range(0, 5) == 0);
            do_instr(instr, $urandom_range(0, 3), 1'($urandom), stop);
            if (stop) begin
                for (int i = 0; i < int'($urandom_range(1, 4)); i++) begin
                    imem_ack = 1'($urandom);
                    step();
                end
                imem_ack = 1'b0;
                n_tests++;
                if (busy !== 1'b0 || pc !== m_pc) begin
                    n_fail++; $display("FAIL stop_idle: busy=%0b pc=%08h, required 0 / %08h", busy, pc, m_pc);
                end
                start_fetch();
            end
        end
    endtask

    task automatic test_reset_mid_fetch();
        // Retired is nonzero here from the random run; drop reset mid-FETCH.
        imem_ack = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || imem_req !== 1'b0 || pc !== 32'h0 || imem_addr !== 32'h0
            || fault !== 1'b0 || retired !== 16'h0 || wr_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_async: busy=%0b req=%0b pc=%08h fault=%0b retired=%0d, required 0/0/0/0/0",
                               busy, imem_req, pc, fault, retired);
        end
        $display("[TB] asynchronous reset mid-fetch checked");
        apply_reset();
    endtask

    task automatic test_timeout();
        int  n;
        bit  frozen;
        apply_reset();
        start_fetch();
        imem_ack = 1'b0;
        n = 0;
        while (imem_req === 1'b1 && n < 40) begin
            n++;
            step();
        end
        n_tests++;
        if (n != TIMEOUT || fault !== 1'b1 || fault_code !== 2'b10) begin
            n_fail++; $display("FAIL timeout: fetch cycles=%0d fault=%0b code=%02b, required %0d / 1 / 10",
                               n, fault, fault_code, TIMEOUT);
        end
        frozen = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run = 1'($urandom); imem_ack = 1'($urandom); imem_data = 32'h0200_0000;
            step();
            if (fault !== 1'b1 || fault_code !== 2'b10 || imem_req !== 1'b0 || wr_en !== 1'b0
                || busy !== 1'b0 || pc !== 32'h0) frozen = 1'b0;
        end
        n_tests++;
        if (frozen !== 1'b1) begin
            n_fail++; $display("FAIL timeout_sticky: state left fault, required frozen (last pc=%08h)", pc);
        end
        $display("[TB] fetch timeout after %0d cycles", n);
    endtask

    task automatic test_illegal();
        logic [7:0] ops [4];
        logic [31:0] instr;
        bit wr_any;
        ops[0] = 8'hFF;
        ops[1] = 8'h08;
        ops[2] = BR_EN ? 8'h80 : 8'h06;
        ops[3] = BR_EN ? 8'hC3 : 8'h07;
        for (int k = 0; k < 4; k++) begin
            apply_reset();
            start_fetch();
            do_instr(32'h0203_0102, 0, 1'b0, 1'b0);
            instr = {ops[k], 24'($urandom) | 24'h07_0000};
            imem_ack = 1'b1; imem_data = instr;
            step();
            imem_ack = 1'b0;
            wr_any = wr_en;
            step();
            n_tests++;
            if (fault !== 1'b1 || fault_code !== 2'b01 || busy !== 1'b0 || pc !== 32'h4) begin
                n_fail++; $display("FAIL illegal: op=%02h fault=%0b code=%02b busy=%0b pc=%08h, required 1 / 01 / 0 / 00000004",
                                   ops[k], fault, fault_code, busy, pc);
            end
            for (int i = 0; i < 6; i++) begin
                run = 1'($urandom); imem_ack = 1'($urandom);
                wr_any |= wr_en;
                step();
            end
            n_tests++;
            if (wr_any !== 1'b0 || pc !== 32'h4 || fault_code !== 2'b01 || retired !== 16'd1) begin
                n_fail++; $display("FAIL illegal_frozen: op=%02h wr_seen=%0b pc=%08h code=%02b retired=%0d, required 0 / 00000004 / 01 / 1",
                                   ops[k], wr_any, pc, fault_code, retired);
            end
            $display("[TB] illegal opcode %02h faulted", ops[k]);
        end
    endtask

`ifdef CPU_SEQ_BRANCH_EN
    task automatic test_branch();
        apply_reset();
        start_fetch();
        do_instr(32'h0203_0102, 0, 1'b0, 1'b0);
        do_instr(32'h0204_0102, 1, 1'b0, 1'b0);
        do_instr(32'h07FE_0112, 0, 1'b1, 1'b0);
        n_tests++;
        if (pc !== 32'h4) begin
            n_fail++; $display("FAIL beq_taken: pc=%08h, required 00000004", pc);
        end
        do_instr(32'h0201_0102, 0, 1'b0, 1'b0);
        do_instr(32'h07FE_0112, 2, 1'b0, 1'b0);
        n_tests++;
        if (pc !== 32'hC) begin
            n_fail++; $display("FAIL beq_not_taken: pc=%08h, required 0000000C", pc);
        end
        apply_reset();
        start_fetch();
        do_instr(32'h06FE_0000, 0, 1'b0, 1'b0);
        n_tests++;
        if (pc !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL jmp_back: pc=%08h, required FFFFFFFC", pc);
        end
        do_instr(32'h067F_0000, 0, 1'b1, 1'b0);
        n_tests++;
        if (pc !== 32'h0000_01FC) begin
            n_fail++; $display("FAIL jmp_wrap: pc=%08h, required 000001FC", pc);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_loadi_wait();
        test_random();
        test_reset_mid_fetch();
        test_timeout();
        test_illegal();
`ifdef CPU_SEQ_BRANCH_EN
        test_branch();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
